// File: rtl/boot_sequencer.sv
// Power-up and boot controller for the BubbleDrive8 board: filters power_good, waits out a
// settle time, drives the SPI image loader with retries, then releases the bubble interface.
module boot_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 8191,
   parameter int unsigned LOAD_TIMEOUT  = 65535,
   parameter int unsigned RETRY_LIMIT   = 2
) (
   input  logic       master_clock,
   input  logic       reset,
   input  logic       power_good,
   input  logic [2:0] image_dip_switch,
   input  logic       spi_load_done,
   input  logic       spi_load_error,
   output logic [2:0] image_number,
   output logic       spi_load_start,
   output logic       temperature_low,
   output logic       bubble_module_enable,
   output logic       boot_fault,
   output logic [2:0] boot_state
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_LATCH  = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_FAULT  = 3'd5;

   localparam logic [16:0] SETTLE_LAST = 17'(SETTLE_CYCLES - 1);
   localparam logic [16:0] LOAD_LAST   = 17'(LOAD_TIMEOUT - 1);
   localparam logic [1:0]  RETRY_MAX   = 2'(RETRY_LIMIT);

   logic [2:0]  pg_sync_q;
   logic        pg_s_q;
   logic [2:0]  state_q, state_d;
   logic [16:0] counter_q, counter_d, counter_inc;
   logic [1:0]  retries_q, retries_d;
   logic [2:0]  image_q, image_d;
   logic        start_q, start_d;
   logic        ready_q, enable_q, fault_q;
   logic        load_done, load_error, load_fail;

   // pg_s rises as soon as the second stage sees power_good, but only falls once all three
   // stages are low, so drops shorter than three cycles never reach the FSM.
   always_ff @(posedge master_clock) begin
      if (reset) begin
         pg_sync_q <= 3'b000;
         pg_s_q    <= 1'b0;
      end else begin
         pg_sync_q <= {pg_sync_q[1:0], power_good};
         if (pg_sync_q[1]) begin
            pg_s_q <= 1'b1;
         end else if (pg_sync_q == 3'b000) begin
            pg_s_q <= 1'b0;
         end
      end
   end

   assign counter_inc = (counter_q == '1) ? counter_q : counter_q + 17'd1;

   // Loader responses are masked while our own start pulse is still on the wire.
   assign load_done  = spi_load_done & ~start_q;
   assign load_error = spi_load_error & ~start_q;
   assign load_fail  = load_error | ((counter_q == LOAD_LAST) & ~load_done);

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      retries_d = retries_q;
      image_d   = image_q;
      start_d   = 1'b0;
      if ((state_q != ST_IDLE) && !pg_s_q) begin
         state_d   = ST_IDLE;
         counter_d = '0;
         retries_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pg_s_q) begin
                  state_d   = ST_SETTLE;
                  counter_d = '0;
               end
            end
            ST_SETTLE: begin
               counter_d = counter_inc;
               if (counter_q == SETTLE_LAST) begin
                  state_d = ST_LATCH;
               end
            end
            ST_LATCH: begin
               image_d   = ~image_dip_switch;
               counter_d = '0;
               retries_d = '0;
               start_d   = 1'b1;
               state_d   = ST_LOAD;
            end
            ST_LOAD: begin
               counter_d = counter_inc;
               if (load_fail) begin
                  if (retries_q < RETRY_MAX) begin
                     retries_d = retries_q + 2'd1;
                     counter_d = '0;
                     start_d   = 1'b1;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end else if (load_done) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN, ST_FAULT: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge master_clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         retries_q <= '0;
         image_q   <= 3'b000;
         start_q   <= 1'b0;
         ready_q   <= 1'b0;
         enable_q  <= 1'b1;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         retries_q <= retries_d;
         image_q   <= image_d;
         start_q   <= start_d;
         ready_q   <= (state_d == ST_RUN);
         enable_q  <= (state_d != ST_RUN);
         fault_q   <= (state_d == ST_FAULT);
      end
   end

   assign image_number         = image_q;
   assign spi_load_start       = start_q;
   assign temperature_low      = ready_q;
   assign bubble_module_enable = enable_q;
   assign boot_fault           = fault_q;
   assign boot_state           = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: directed and randomized boots, with start pulses, RUN and FAULT
// entry cycles predicted from the boot timing rules.
module tb_boot_sequencer;

   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 32;
   localparam int RETRIES = 2;
   // Cycles from power_good high (cycle c0) to the first start pulse: sync, idle, settle, latch.
   localparam int FIRST_START = 3 + 1 + SETTLE + 1;

   logic       master_clock = 1'b0;
   logic       reset = 1'b1;
   logic       power_good = 1'b0;
   logic [2:0] image_dip_switch = 3'b111;
   logic       spi_load_done = 1'b0;
   logic       spi_load_error = 1'b0;
   logic [2:0] image_number;
   logic       spi_load_start;
   logic       temperature_low;
   logic       bubble_module_enable;
   logic       boot_fault;
   logic [2:0] boot_state;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   starts[$];
   int   ready_cyc = -1;
   int   fault_cyc = -1;
   logic prev_start = 1'b0;
   int   plan_kind[3];  // 0 done, 1 error, 2 silent, 3 done+error
   int   plan_d[3];
   int   last_state = 0;

   boot_sequencer #(
      .SETTLE_CYCLES(SETTLE),
      .LOAD_TIMEOUT (TIMEOUT),
      .RETRY_LIMIT  (RETRIES)
   ) dut (
      .master_clock        (master_clock),
      .reset               (reset),
      .power_good          (power_good),
      .image_dip_switch    (image_dip_switch),
      .spi_load_done       (spi_load_done),
      .spi_load_error      (spi_load_error),
      .image_number        (image_number),
      .spi_load_start      (spi_load_start),
      .temperature_low     (temperature_low),
      .bubble_module_enable(bubble_module_enable),
      .boot_fault          (boot_fault),
      .boot_state          (boot_state)
   );

   always #5 master_clock = ~master_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge master_clock);
      #1;
      cyc++;
      if (spi_load_start) begin
         starts.push_back(cyc);
         check("start_only_in_load", 32'(boot_state), 32'd3);
         check("start_not_back_to_back", 32'(prev_start), 32'd0);
      end
      prev_start = spi_load_start;
      if (temperature_low && ready_cyc < 0) ready_cyc = cyc;
      if (boot_fault && fault_cyc < 0) fault_cyc = cyc;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(boot_state), 32'd0);
      check({tag, "_image"}, 32'(image_number), 32'd0);
      check({tag, "_start"}, 32'(spi_load_start), 32'd0);
      check({tag, "_ready"}, 32'(temperature_low), 32'd0);
      check({tag, "_enable"}, 32'(bubble_module_enable), 32'd1);
      check({tag, "_fault"}, 32'(boot_fault), 32'd0);
   endtask

   task automatic set_plan(input int k0, input int d0, input int k1, input int d1,
                           input int k2, input int d2);
      plan_kind[0] = k0; plan_d[0] = d0;
      plan_kind[1] = k1; plan_d[1] = d1;
      plan_kind[2] = k2; plan_d[2] = d2;
   endtask

   // power_good must already be high in the current cycle (c0) with the DUT idle.
   task automatic run_boot(input logic [2:0] dip, input logic [2:0] other_dip,
                           input bit glitch, input bit noise);
      int         c0, s, nxt, exp_run, exp_fault, stop;
      int         exp_starts[$];
      int         resp_cyc[3];
      bit         ended;
      bit         at_start;
      logic [2:0] exp_img;
      c0 = cyc;
      exp_img = ~dip;
      starts.delete();
      ready_cyc = -1;
      fault_cyc = -1;
      exp_run = -1;
      exp_fault = -1;
      ended = 1'b0;
      s = c0 + FIRST_START;
      for (int a = 0; a <= RETRIES; a++) begin
         resp_cyc[a] = -1;
         if (!ended) begin
            exp_starts.push_back(s);
            if (plan_kind[a] != 2) resp_cyc[a] = s + plan_d[a];
            if (plan_kind[a] == 0) begin
               exp_run = s + plan_d[a] + 1;
               ended = 1'b1;
            end else begin
               nxt = (plan_kind[a] == 2) ? s + TIMEOUT : s + plan_d[a] + 1;
               if (a == RETRIES) begin
                  exp_fault = nxt;
                  ended = 1'b1;
               end else begin
                  s = nxt;
               end
            end
         end
      end
      stop = ((exp_run >= 0) ? exp_run : exp_fault) + 3;
      image_dip_switch = other_dip;
      while (cyc < stop) begin
         spi_load_done = 1'b0;
         spi_load_error = 1'b0;
         at_start = 1'b0;
         for (int a = 0; a < exp_starts.size(); a++) begin
            if (exp_starts[a] == cyc) at_start = 1'b1;
            if (resp_cyc[a] == cyc) begin
               spi_load_done = (plan_kind[a] == 0) || (plan_kind[a] == 3);
               spi_load_error = (plan_kind[a] == 1) || (plan_kind[a] == 3);
            end
         end
         if (noise && at_start) begin
            spi_load_done = 1'b1;
            spi_load_error = 1'b1;
         end
         if (cyc == c0 + FIRST_START - 1) image_dip_switch = dip;
         if (cyc == c0 + FIRST_START) image_dip_switch = other_dip;
         if (glitch && cyc == c0 + 10) power_good = 1'b0;
         if (glitch && cyc == c0 + 12) power_good = 1'b1;
         tick();
      end
      spi_load_done = 1'b0;
      spi_load_error = 1'b0;
      check("start_count", 32'(starts.size()), 32'(exp_starts.size()));
      for (int i = 0; i < exp_starts.size() && i < starts.size(); i++)
         check("start_cycle", 32'(starts[i] - c0), 32'(exp_starts[i] - c0));
      check("ready_rise_cycle", 32'(ready_cyc), 32'(exp_run));
      check("fault_rise_cycle", 32'(fault_cyc), 32'(exp_fault));
      check("image_number", 32'(image_number), 32'(exp_img));
      last_state = (exp_run >= 0) ? 4 : 5;
      check("final_state", 32'(boot_state), 32'(last_state));
      check("final_ready", 32'(temperature_low), (exp_run >= 0) ? 32'd1 : 32'd0);
      check("final_enable", 32'(bubble_module_enable), (exp_run >= 0) ? 32'd0 : 32'd1);
      check("final_fault", 32'(boot_fault), (exp_run >= 0) ? 32'd0 : 32'd1);
   endtask

   // Six-cycle power_good drop; leaves power_good high again in the current cycle.
   task automatic drop_pg(input logic [2:0] exp_img);
      int n;
      n = cyc;
      power_good = 1'b0;
      while (cyc < n + 4) tick();
      check("drop_state_before_idle", 32'(boot_state), 32'(last_state));
      tick();
      check("drop_state", 32'(boot_state), 32'd0);
      check("drop_ready", 32'(temperature_low), 32'd0);
      check("drop_enable", 32'(bubble_module_enable), 32'd1);
      check("drop_fault", 32'(boot_fault), 32'd0);
      check("drop_image_hold", 32'(image_number), 32'(exp_img));
      tick();
      power_good = 1'b1;
   endtask

   initial begin
      logic [2:0] dip, other, prev_img;
      bit         gl, nz;
      int         k[3];
      int         d[3];

      // Reset held with power_good already high.
      reset = 1'b1;
      power_good = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_reset_values("reset");
      end

      // Clean boot: done 10 cycles after the start pulse.
      set_plan(0, 10, 0, 0, 0, 0);
      reset = 1'b0;
      run_boot(3'b101, 3'b110, 1'b0, 1'b0);

      // Error after every start: three attempts then FAULT.
      drop_pg(3'b010);
      set_plan(1, 3, 1, 5, 1, 7);
      run_boot(3'b011, 3'b000, 1'b0, 1'b0);

      // Silent loader: three timeouts, then a drop out of FAULT.
      drop_pg(3'b100);
      set_plan(2, 0, 2, 0, 2, 0);
      run_boot(3'b110, 3'b001, 1'b0, 1'b0);

      // Done and error together count as a failure; the retry then succeeds.
      drop_pg(3'b001);
      set_plan(3, 4, 0, 6, 0, 0);
      run_boot(3'b000, 3'b111, 1'b0, 1'b0);

      // Short glitch in SETTLE, loader noise during start cycles, done on the last legal cycle.
      drop_pg(3'b111);
      set_plan(0, TIMEOUT - 1, 0, 0, 0, 0);
      run_boot(3'b010, 3'b101, 1'b1, 1'b1);

      // Error on the final counter cycle, then a success; re-boot with a fresh DIP.
      drop_pg(3'b101);
      set_plan(1, TIMEOUT - 1, 0, 1, 0, 0);
      run_boot(3'b100, 3'b010, 1'b0, 1'b0);
      prev_img = 3'b011;

      for (int it = 0; it < 14; it++) begin
         drop_pg(prev_img);
         for (int a = 0; a < 3; a++) begin
            k[a] = int'($urandom_range(0, 3));
            d[a] = int'($urandom_range(1, TIMEOUT - 1));
         end
         set_plan(k[0], d[0], k[1], d[1], k[2], d[2]);
         dip = 3'($urandom_range(0, 7));
         other = ~dip;
         gl = 1'($urandom_range(0, 1));
         nz = 1'($urandom_range(0, 1));
         run_boot(dip, other, gl, nz);
         prev_img = ~dip;
      end

      // Reset overrides a running board.
      reset = 1'b1;
      tick();
      check_reset_values("midrun_reset");
      tick();
      check_reset_values("midrun_reset_hold");
      set_plan(0, 2, 0, 0, 0, 0);
      reset = 1'b0;
      run_boot(3'b001, 3'b100, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
